// File: rtl/aes_gcm_pkg.sv
// Shared types, constants and the GF(2^128) single-bit step for the GCM datapath.
// Vectors are [127:0] with GCM bit 0 (the leftmost, most significant bit) at index 127.
package aes_gcm_pkg;

  typedef enum logic [2:0] {
    PH_NOP  = 3'd0,
    PH_AAD  = 3'd1,
    PH_TEXT = 3'd2,
    PH_LEN  = 3'd3
  } phase_e;

  // Reduction constant 0xE1 || 0^120
  localparam logic [127:0] GF128_R = 128'hE1 << 120;

  // One multiplier bit: conditionally fold V into Z, then advance V by one power of x.
  function automatic logic [255:0] gf128_step(input logic [127:0] z,
                                              input logic [127:0] v,
                                              input logic         xbit);
    logic [127:0] z_n;
    logic [127:0] v_n;
    z_n = xbit ? (z ^ v) : z;
    v_n = (v >> 1) ^ (v[0] ? GF128_R : 128'h0);
    return {z_n, v_n};
  endfunction

endpackage

// File: rtl/gf128_mul_serial.sv
// Serial GF(2^128) multiplier: Z = X * H, BITS_PER_CYCLE bits of X per clock.
// done_o and product_o are combinational and valid during the last multiply cycle,
// so the caller can capture the product on the same edge that finishes the multiply.
module gf128_mul_serial
  import aes_gcm_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] x_i,
  input  logic [127:0] h_i,
  output logic         done_o,
  output logic [127:0] product_o
);

  localparam int unsigned N    = 128 / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [127:0]      x_q, x_d;
  logic [127:0]      z_q, z_d;
  logic [127:0]      v_q, v_d;
  logic [127:0]      z_step, v_step;
  logic              last;

  // Apply BITS_PER_CYCLE single-bit steps, consuming X from its most significant end.
  always_comb begin
    logic [127:0] xs;
    z_step = z_q;
    v_step = v_q;
    xs     = x_q;
    for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
      {z_step, v_step} = gf128_step(z_step, v_step, xs[127]);
      xs = xs << 1;
    end
  end

  assign last      = busy_q && (cnt_q == CntLast);
  assign done_o    = last;
  assign product_o = z_step;

  // Next-state: load operands on start, otherwise step while busy.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    z_d    = z_q;
    v_d    = v_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      x_d    = x_i;
      z_d    = '0;
      v_d    = h_i;
    end else if (busy_q) begin
      z_d    = z_step;
      v_d    = v_step;
      x_d    = x_q << BITS_PER_CYCLE;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      busy_d = !last;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      z_q    <= '0;
      v_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      z_q    <= z_d;
      v_q    <= v_d;
    end
  end

endmodule

// File: rtl/aes_gcm_ghash_ctr_stage.sv
// Final AES-GCM stage: CTR XOR for ciphertext, GHASH accumulation and tag output.
module aes_gcm_ghash_ctr_stage
  import aes_gcm_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_phase,
  input  logic [127:0] i_h,
  input  logic [127:0] i_encrypted_cb,
  input  logic [127:0] i_encrypted_j0,
  input  logic [127:0] i_plain_text,
  input  logic [127:0] i_aad,
  input  logic [127:0] i_instance_size,
  input  logic [15:0]  i_byte_valid,
  output logic [127:0] o_cipher_text,
  output logic         o_ct_valid,
  output logic [127:0] o_tag,
  output logic         o_tag_valid
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;

  logic         state_q, state_d;
  logic [127:0] y_q, y_d;
  logic [127:0] ej0_q, ej0_d;
  logic         len_q, len_d;
  logic [127:0] ct_q, ct_d;
  logic         ct_valid_q, ct_valid_d;
  logic [127:0] tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;

  logic         is_aad, is_text, is_len, is_hash;
  logic         accept, mul_start, mul_done;
  logic [127:0] byte_mask, ct_calc, x_in, product;

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid && o_ready;

  assign is_aad  = (i_phase == PH_AAD);
  assign is_text = (i_phase == PH_TEXT);
  assign is_len  = (i_phase == PH_LEN);
  assign is_hash = is_aad || is_text || is_len;

  assign mul_start = accept && is_hash;

  // Byte j of the mask covers the j-th byte counting from the most significant end.
  always_comb begin
    byte_mask = '0;
    for (int j = 0; j < 16; j++) begin
      byte_mask[127-8*j -: 8] = {8{i_byte_valid[15-j]}};
    end
  end

  assign ct_calc = (i_plain_text ^ i_encrypted_cb) & byte_mask;

  // Block folded into the running hash before multiplication by H.
  always_comb begin
    x_in = y_q ^ i_instance_size;
    if (is_aad) begin
      x_in = y_q ^ i_aad;
    end else if (is_text) begin
      x_in = y_q ^ ct_calc;
    end
  end

  gf128_mul_serial #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .x_i       (x_in),
    .h_i       (i_h),
    .done_o    (mul_done),
    .product_o (product)
  );

  // FSM and datapath next-state; output pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    ej0_d       = ej0_q;
    len_d       = len_q;
    ct_d        = ct_q;
    ct_valid_d  = 1'b0;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL;
          len_d   = is_len;
          if (is_text) begin
            ct_d       = ct_calc;
            ct_valid_d = 1'b1;
          end
          if (is_len) begin
            ej0_d = i_encrypted_j0;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_IDLE;
          if (len_q) begin
            tag_d       = product ^ ej0_q;
            tag_valid_d = 1'b1;
            y_d         = '0;
          end else begin
            y_d = product;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      ej0_q       <= '0;
      len_q       <= 1'b0;
      ct_q        <= '0;
      ct_valid_q  <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      ej0_q       <= ej0_d;
      len_q       <= len_d;
      ct_q        <= ct_d;
      ct_valid_q  <= ct_valid_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign o_cipher_text = ct_q;
  assign o_ct_valid    = ct_valid_q;
  assign o_tag         = tag_q;
  assign o_tag_valid   = tag_valid_q;

endmodule

// File: doc/aes_gcm_ghash_ctr_stage.md
# aes_gcm_ghash_ctr_stage

Final datapath stage of the AES-GCM pipeline. It consumes the fully encrypted H, the counter-block keystream E(K,CB) and E(K,J0) from the last AES round stage, together with the carried-forward phase, plaintext, AAD and length block. It XORs keystream with plaintext to produce ciphertext. It accumulates GHASH with a multi-cycle GF(2^128) multiplier, and emits the authentication tag when it processes the length block.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits consumed per cycle; must divide 128 (1, 2, 4, 8, 16). N = 128/BITS_PER_CYCLE.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: input block valid.
- `o_ready` out 1: block can accept input this cycle.
- `i_phase` in [0:2]: 0 NOP, 1 AAD, 2 TEXT, 3 LEN, 4–7 reserved (treated as NOP).
- `i_h` in [0:127]: hash subkey H = E(K,0^128).
- `i_encrypted_cb` in [0:127]: keystream E(K,CB) for this TEXT block.
- `i_encrypted_j0` in [0:127]: E(K,J0), sampled on LEN.
- `i_plain_text` in [0:127]: plaintext block (TEXT).
- `i_aad` in [0:127]: AAD block (AAD), zero-padded by upstream.
- `i_instance_size` in [0:127]: len(A)||len(C) in bits (LEN).
- `i_byte_valid` in [0:15]: TEXT byte mask; bit j covers bits 8j..8j+7.
- `o_cipher_text` out [0:127]: ciphertext block.
- `o_ct_valid` out 1: one-cycle pulse, o_cipher_text valid.
- `o_tag` out [0:127]: authentication tag.
- `o_tag_valid` out 1: one-cycle pulse, o_tag valid.

## Operation
- Accept = i_valid && o_ready. o_ready = (state == IDLE), driven combinationally from state.
- States:
  - IDLE → MUL on accepting AAD, TEXT or LEN.
  - MUL → IDLE after N multiply cycles.
  - NOP or reserved phase is accepted and dropped; the block stays in IDLE.
- On accepting an AAD block: X ← Y ⊕ i_aad.
- On accepting a TEXT block:
  - C = (i_plain_text ⊕ i_encrypted_cb), with bytes zeroed where i_byte_valid = 0.
  - o_cipher_text ← C and o_ct_valid ← 1 on the accepting edge.
  - X ← Y ⊕ C.
- On accepting a LEN block: X ← Y ⊕ i_instance_size, and E(J0) is latched.
- At every multiply start: V ← i_h, Z ← 0, counter ← 0. H is sampled per block; no cross-block H register is used.
- Each MUL cycle processes bits i = counter·BITS_PER_CYCLE … +BITS_PER_CYCLE−1 of X, where bit 0 is the MSB:
  - if X[i] = 1, Z ^= V;
  - then V ← (V >> 1) ⊕ (V[127] ? R : 0), with R = 0xE1 || 0^120;
  - counter increments.
- Last MUL edge (counter = N−1):
  - AAD or TEXT: Y ← Z_final.
  - LEN: o_tag ← Z_final ⊕ E(J0), o_tag_valid ← 1, and Y ← 0, ready for the next message.
- Arithmetic is pure XOR/shift over 128 bits; no carries or truncation.

## Timing
- Accept at edge T. MUL occupies edges T+1 … T+N. o_ready is high again in the cycle after edge T+N. Sustained throughput is one hashed block per N+1 cycles.
- o_ct_valid is asserted in the cycle after edge T.
- o_tag_valid is asserted in the cycle after edge T+N.
- Both pulses are exactly one cycle. o_cipher_text and o_tag hold their value until next overwritten.
- i_valid while not ready: ignored. Upstream must hold the block; no buffering here.
- NOP accept: no output pulse, no busy cycle.
- Reset values: state IDLE, Y = 0, counter = 0, o_cipher_text = 0, o_tag = 0, o_ct_valid = 0, o_tag_valid = 0. o_ready = 1 in the first cycle after reset.
- rst during MUL aborts the multiply and discards Y; no tag is emitted. rst wins over a simultaneous accept.
- TEXT with i_byte_valid = 0x0000 still multiplies, with C = 0. Ciphertext is output as all zeros with a valid pulse.

## Structure
- Package `aes_gcm_pkg`:
  - phase enum (`PH_NOP`, `PH_AAD`, `PH_TEXT`, `PH_LEN`);
  - constant `GF128_R = 128'hE1 << 120`;
  - function `gf128_step(Z, V, xbit)` returning the updated {Z, V}.
- Sub-module `gf128_mul_serial`, parameter BITS_PER_CYCLE:
  - start/operands in; done pulse and product out;
  - owns V, Z and the counter.
- The top level owns the FSM, Y, the latched E(J0), the CTR XOR and the output registers.

## Test plan
- NIST GCM TC1: H = 66e94bd4ef8a2c3b884cfa59ca342b2e, single LEN block of 0, E(J0) = 58e2fccefa7e3061367f1d57a4e7455a → o_tag = 58e2fccefa7e3061367f1d57a4e7455a, o_tag_valid at T+N+1.
- NIST GCM TC2: TEXT with P = 0, E(CB) = 0388dace60b6a392f328c2b971b2fe78, mask 0xFFFF; then LEN = 0…0080 with the same H and E(J0) → ct = 0388dace60b6a392f328c2b971b2fe78, tag = ab6e47d42cec13bdf53a67b21257bddf.
- Identity H = 8000…0: AAD = 0123…ef, LEN = 0…0080, E(J0) = 0 → tag = AAD ⊕ LEN.
- Back-to-back: i_valid held high across 3 TEXT blocks → o_ready low for exactly N cycles each, no block dropped or duplicated; sweep BITS_PER_CYCLE ∈ {1, 8}.
- Partial block: mask 0xFFF0 → ct bytes 12–15 = 0, and the tag matches the reference model using the zeroed C.
- rst asserted mid-MUL at counter = 40 → o_ready = 1 next cycle, no tag pulse; a following TC1 sequence gives the correct tag, proving Y was cleared.
